ring_sweep_meter: RTL and testbench

Automated, parametrised successor to the manual ring-oscillator range test. It drives the ring oscillator's frequency-select code and enable, and counts ring-clock rising edges over a fixed gate window of the FPGA clock. It reports one count per code, either for a single code or a full ascending sweep, and tracks the minimum and maximum counts over a sweep. It sits between the ring oscillator and the display/host logic, replacing hand-set switches during ring characterisation.

---
 rtl/ring_sweep_pkg.sv | 19 +
 rtl/ring_edge_sync.sv | 19 +
 rtl/ring_sweep_meter.sv | 209 ++++++++++++++++++++
 tb/tb_ring_sweep_meter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_sweep_pkg.sv
// Shared types and limits for the ring oscillator sweep meter.
package ring_sweep_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_GATE,
      ST_REPORT,
      ST_DONE
   } state_e;

   localparam int unsigned MIN_GATE_CYCLES   = 2;
   localparam int unsigned MIN_SETTLE_CYCLES = 1;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ring_edge_sync.sv
// Two-flop synchroniser for an asynchronous input plus a rising-edge pulse.
module ring_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise_c
);

   logic [2:0] sh_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sh_q <= '0;
      else        sh_q <= {sh_q[1:0], d};
   end

   // sh_q[2] is the edge-detect history of the synchronised level sh_q[1]
   assign rise_c = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/ring_sweep_meter.sv
// Drives the ring oscillator code/enable and counts ring edges over a fixed gate,
// for a single code or an ascending sweep with min/max tracking.
module ring_sweep_meter
   import ring_sweep_pkg::*;
#(
   parameter int unsigned CTRL_WIDTH    = 5,
   parameter int unsigned COUNT_WIDTH   = 16,
   parameter int unsigned GATE_CYCLES   = 16000,
   parameter int unsigned SETTLE_CYCLES = 256
) (
   input  logic                   fpga_clk_i,
   input  logic                   rst_n_i,
   input  logic                   start_i,
   input  logic                   sweep_i,
   input  logic [CTRL_WIDTH-1:0]  code_i,
   input  logic                   abort_i,
   input  logic                   ring_clk_i,
   output logic                   ring_en_o,
   output logic [CTRL_WIDTH-1:0]  freq_sel_o,
   output logic                   busy_o,
   output logic                   result_valid_o,
   output logic [CTRL_WIDTH-1:0]  result_code_o,
   output logic [COUNT_WIDTH-1:0] result_count_o,
   output logic                   result_sat_o,
   output logic                   done_o,
   output logic [COUNT_WIDTH-1:0] min_count_o,
   output logic [COUNT_WIDTH-1:0] max_count_o
);

   localparam int unsigned GATE_N   = max_u(GATE_CYCLES, MIN_GATE_CYCLES);
   localparam int unsigned SETTLE_N = max_u(SETTLE_CYCLES, MIN_SETTLE_CYCLES);
   localparam int unsigned TMR_W    = $clog2(max_u(GATE_N, SETTLE_N) + 1);

   state_e                 state_q, state_d;
   logic [TMR_W-1:0]       tmr_q, tmr_d;
   logic                   sweep_q, sweep_d;
   logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
   logic                   edge_sat_q, edge_sat_d;
   logic [COUNT_WIDTH-1:0] run_min_q, run_min_d;
   logic [COUNT_WIDTH-1:0] run_max_q, run_max_d;

   logic                   ring_en_d;
   logic [CTRL_WIDTH-1:0]  freq_sel_d;
   logic                   busy_d;
   logic                   result_valid_d;
   logic [CTRL_WIDTH-1:0]  result_code_d;
   logic [COUNT_WIDTH-1:0] result_count_d;
   logic                   result_sat_d;
   logic                   done_d;
   logic [COUNT_WIDTH-1:0] min_count_d;
   logic [COUNT_WIDTH-1:0] max_count_d;

   logic                   ring_rise_c;

   ring_edge_sync u_sync (
      .clk    (fpga_clk_i),
      .rst_n  (rst_n_i),
      .d      (ring_clk_i),
      .rise_c (ring_rise_c)
   );

   // Next-state and next-output logic
   always_comb begin
      state_d        = state_q;
      tmr_d          = tmr_q;
      sweep_d        = sweep_q;
      edge_cnt_d     = edge_cnt_q;
      edge_sat_d     = edge_sat_q;
      run_min_d      = run_min_q;
      run_max_d      = run_max_q;
      ring_en_d      = ring_en_o;
      freq_sel_d     = freq_sel_o;
      result_valid_d = 1'b0;
      result_code_d  = result_code_o;
      result_count_d = result_count_o;
      result_sat_d   = result_sat_o;
      done_d         = 1'b0;
      min_count_d    = min_count_o;
      max_count_d    = max_count_o;

      // Saturating edge count; the last gate cycle's edge is included in the result
      if (state_q == ST_GATE && ring_rise_c) begin
         if (&edge_cnt_q) edge_sat_d = 1'b1;
         else             edge_cnt_d = COUNT_WIDTH'(edge_cnt_q + 1'b1);
      end

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               sweep_d    = sweep_i;
               freq_sel_d = sweep_i ? '0 : code_i;
               ring_en_d  = 1'b1;
               tmr_d      = TMR_W'(SETTLE_N - 1);
               state_d    = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (tmr_q == '0) begin
               tmr_d      = TMR_W'(GATE_N - 1);
               edge_cnt_d = '0;
               edge_sat_d = 1'b0;
               state_d    = ST_GATE;
            end else begin
               tmr_d = TMR_W'(tmr_q - 1'b1);
            end
         end
         ST_GATE: begin
            if (tmr_q == '0) begin
               state_d        = ST_REPORT;
               result_valid_d = 1'b1;
               result_code_d  = freq_sel_o;
               result_count_d = edge_cnt_d;
               result_sat_d   = edge_sat_d;
               if (sweep_q) begin
                  if (freq_sel_o == '0) begin
                     run_min_d = edge_cnt_d;
                     run_max_d = edge_cnt_d;
                  end else begin
                     if (edge_cnt_d < run_min_q) run_min_d = edge_cnt_d;
                     if (edge_cnt_d > run_max_q) run_max_d = edge_cnt_d;
                  end
               end
            end else begin
               tmr_d = TMR_W'(tmr_q - 1'b1);
            end
         end
         ST_REPORT: begin
            if (sweep_q && !(&freq_sel_o)) begin
               freq_sel_d = CTRL_WIDTH'(freq_sel_o + 1'b1);
               tmr_d      = TMR_W'(SETTLE_N - 1);
               state_d    = ST_SETTLE;
            end else begin
               done_d  = 1'b1;
               state_d = ST_DONE;
               if (sweep_q) begin
                  min_count_d = run_min_q;
                  max_count_d = run_max_q;
               end
            end
         end
         ST_DONE: begin
            ring_en_d = 1'b0;
            state_d   = ST_IDLE;
         end
         default: begin
            ring_en_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase

      // Abort beats every other transition and leaves published results untouched
      if (abort_i && state_q != ST_IDLE) begin
         state_d        = ST_IDLE;
         ring_en_d      = 1'b0;
         freq_sel_d     = freq_sel_o;
         result_valid_d = 1'b0;
         result_code_d  = result_code_o;
         result_count_d = result_count_o;
         result_sat_d   = result_sat_o;
         done_d         = 1'b0;
         min_count_d    = min_count_o;
         max_count_d    = max_count_o;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs
   always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q        <= ST_IDLE;
         tmr_q          <= '0;
         sweep_q        <= 1'b0;
         edge_cnt_q     <= '0;
         edge_sat_q     <= 1'b0;
         run_min_q      <= '0;
         run_max_q      <= '0;
         ring_en_o      <= 1'b0;
         freq_sel_o     <= '0;
         busy_o         <= 1'b0;
         result_valid_o <= 1'b0;
         result_code_o  <= '0;
         result_count_o <= '0;
         result_sat_o   <= 1'b0;
         done_o         <= 1'b0;
         min_count_o    <= '0;
         max_count_o    <= '0;
      end else begin
         state_q        <= state_d;
         tmr_q          <= tmr_d;
         sweep_q        <= sweep_d;
         edge_cnt_q     <= edge_cnt_d;
         edge_sat_q     <= edge_sat_d;
         run_min_q      <= run_min_d;
         run_max_q      <= run_max_d;
         ring_en_o      <= ring_en_d;
         freq_sel_o     <= freq_sel_d;
         busy_o         <= busy_d;
         result_valid_o <= result_valid_d;
         result_code_o  <= result_code_d;
         result_count_o <= result_count_d;
         result_sat_o   <= result_sat_d;
         done_o         <= done_d;
         min_count_o    <= min_count_d;
         max_count_o    <= max_count_d;
      end
   end

endmodule

// File: tb/tb_ring_sweep_meter.sv
// Directed bench for ring_sweep_meter: single, sweep, saturation, abort, async reset.
module tb_ring_sweep_meter;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int checks = 0;
   int passed = 0;

   // dut_a: single-mode timing, 5-bit code, gate 1000, settle 16
   logic        a_start = 0, a_sweep = 0, a_abort = 0, ring_a = 0;
   logic [4:0]  a_code = '0;
   logic        a_ring_en, a_busy, a_valid, a_sat, a_done;
   logic [4:0]  a_freq_sel, a_res_code;
   logic [15:0] a_res_count, a_min, a_max;

   // dut_b: 3-bit sweep, gate 1200, settle 64
   logic        b_start = 0, b_sweep = 0, b_abort = 0, ring_b = 0;
   logic [2:0]  b_code = '0;
   logic        b_ring_en, b_busy, b_valid, b_sat, b_done;
   logic [2:0]  b_freq_sel, b_res_code;
   logic [15:0] b_res_count, b_min, b_max;

   // dut_c: 4-bit saturating counter, gate 400
   logic        c_start = 0, c_sweep = 0, c_abort = 0, ring_c = 0;
   logic [4:0]  c_code = '0;
   logic        c_ring_en, c_busy, c_valid, c_sat, c_done;
   logic [4:0]  c_freq_sel, c_res_code;
   logic [3:0]  c_res_count, c_min, c_max;

   ring_sweep_meter #(.CTRL_WIDTH(5), .COUNT_WIDTH(16), .GATE_CYCLES(1000), .SETTLE_CYCLES(16)) dut_a (
      .fpga_clk_i(clk), .rst_n_i(rst_n), .start_i(a_start), .sweep_i(a_sweep), .code_i(a_code),
      .abort_i(a_abort), .ring_clk_i(ring_a), .ring_en_o(a_ring_en), .freq_sel_o(a_freq_sel),
      .busy_o(a_busy), .result_valid_o(a_valid), .result_code_o(a_res_code),
      .result_count_o(a_res_count), .result_sat_o(a_sat), .done_o(a_done),
      .min_count_o(a_min), .max_count_o(a_max));

   ring_sweep_meter #(.CTRL_WIDTH(3), .COUNT_WIDTH(16), .GATE_CYCLES(1200), .SETTLE_CYCLES(64)) dut_b (
      .fpga_clk_i(clk), .rst_n_i(rst_n), .start_i(b_start), .sweep_i(b_sweep), .code_i(b_code),
      .abort_i(b_abort), .ring_clk_i(ring_b), .ring_en_o(b_ring_en), .freq_sel_o(b_freq_sel),
      .busy_o(b_busy), .result_valid_o(b_valid), .result_code_o(b_res_code),
      .result_count_o(b_res_count), .result_sat_o(b_sat), .done_o(b_done),
      .min_count_o(b_min), .max_count_o(b_max));

   ring_sweep_meter #(.CTRL_WIDTH(5), .COUNT_WIDTH(4), .GATE_CYCLES(400), .SETTLE_CYCLES(16)) dut_c (
      .fpga_clk_i(clk), .rst_n_i(rst_n), .start_i(c_start), .sweep_i(c_sweep), .code_i(c_code),
      .abort_i(c_abort), .ring_clk_i(ring_c), .ring_en_o(c_ring_en), .freq_sel_o(c_freq_sel),
      .busy_o(c_busy), .result_valid_o(c_valid), .result_code_o(c_res_code),
      .result_count_o(c_res_count), .result_sat_o(c_sat), .done_o(c_done),
      .min_count_o(c_min), .max_count_o(c_max));

   // Clock period 10; ring toggles are offset so they never coincide with a rising edge
   always #5 clk = ~clk;
   initial begin #3; forever #100 ring_a = ~ring_a; end
   initial begin #7; forever #((10 + 4 * int'(b_freq_sel)) * 5) ring_b = ~ring_b; end
   initial begin #1; forever #40 ring_c = ~ring_c; end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #12;
      checks++;
      if ({a_busy, a_ring_en, a_valid, a_done, a_sat} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {a_busy, a_ring_en, a_valid, a_done, a_sat});
      else passed++;
      checks++;
      if ({a_freq_sel, a_res_code} !== 10'd0) $display("FAIL reset_codes: got %h want 0", {a_freq_sel, a_res_code});
      else passed++;
      checks++;
      if ({a_res_count, a_min, a_max} !== 48'd0) $display("FAIL reset_counts: got %h want 0", {a_res_count, a_min, a_max});
      else passed++;
      #5 rst_n = 1'b1;
      tick;
   endtask

   task automatic test_single_and_busy_start;
      int  n;
      bit  seen;
      a_code = 5'd7; a_sweep = 1'b0; a_start = 1'b1;
      tick; n = 1;
      a_start = 1'b0;
      checks++;
      if ({a_busy, a_ring_en, a_freq_sel} !== {1'b1, 1'b1, 5'd7}) $display("FAIL single_launch: got %b want 1100111", {a_busy, a_ring_en, a_freq_sel});
      else passed++;
      tick; tick; n = 3;
      a_code = 5'd12; a_start = 1'b1;
      tick; n = 4;
      a_start = 1'b0;
      checks++;
      if (a_freq_sel !== 5'd7) $display("FAIL busy_start_ignored: freq_sel %0d want 7", a_freq_sel);
      else passed++;
      seen = 0;
      while (n < 2000 && !seen) begin
         tick; n++;
         if (a_valid) seen = 1;
      end
      checks++;
      if (!seen) $display("FAIL single_valid_timeout: no result_valid within %0d cycles", n);
      else passed++;
      checks++;
      if (n !== 1017) $display("FAIL single_latency: got %0d want 1017", n);
      else passed++;
      checks++;
      if (a_res_code !== 5'd7) $display("FAIL single_code: got %0d want 7", a_res_code);
      else passed++;
      checks++;
      if (a_res_count < 16'd49 || a_res_count > 16'd51) $display("FAIL single_count: got %0d want 50+-1", a_res_count);
      else passed++;
      checks++;
      if (a_sat !== 1'b0) $display("FAIL single_sat: got %b want 0", a_sat);
      else passed++;
      tick;
      checks++;
      if ({a_done, a_valid, a_busy} !== 3'b101) $display("FAIL single_done_pulse: done/valid/busy %b want 101", {a_done, a_valid, a_busy});
      else passed++;
      tick;
      checks++;
      if ({a_done, a_busy, a_ring_en} !== 3'b000) $display("FAIL single_end: done/busy/en %b want 000", {a_done, a_busy, a_ring_en});
      else passed++;
      checks++;
      if ({a_min, a_max} !== 32'd0) $display("FAIL single_minmax_untouched: got %h want 0", {a_min, a_max});
      else passed++;
   endtask

   task automatic test_saturation;
      int n;
      c_code = 5'd3; c_start = 1'b1;
      tick; c_start = 1'b0;
      n = 1;
      while (n < 1000 && !c_valid) begin tick; n++; end
      checks++;
      if (!c_valid) $display("FAIL sat_timeout: no result_valid within %0d cycles", n);
      else passed++;
      checks++;
      if ({c_res_count, c_sat} !== {4'd15, 1'b1}) $display("FAIL sat_count: count %0d sat %b want 15 1", c_res_count, c_sat);
      else passed++;
      checks++;
      if (c_res_code !== 5'd3) $display("FAIL sat_code: got %0d want 3", c_res_code);
      else passed++;
      repeat (4) tick;
   endtask

   task automatic test_sweep;
      int        exp_cnt [8] = '{120, 85, 66, 54, 46, 40, 35, 31};
      int        got_code[8];
      int        got_cnt [8];
      int        pulses, n, n_last, n_done, en_drops;
      pulses = 0; n_last = -1; n_done = -1; en_drops = 0;
      b_sweep = 1'b1; b_start = 1'b1;
      tick; b_start = 1'b0; b_sweep = 1'b0;
      n = 1;
      while (n < 12000 && n_done < 0) begin
         if (b_busy && !b_ring_en) en_drops++;
         if (b_valid) begin
            if (pulses < 8) begin
               got_code[pulses] = int'(b_res_code);
               got_cnt[pulses]  = int'(b_res_count);
            end
            pulses++;
            n_last = n;
         end
         if (b_done) n_done = n;
         tick; n++;
      end
      checks++;
      if (n_done < 0) $display("FAIL sweep_timeout: no done within %0d cycles", n);
      else passed++;
      checks++;
      if (pulses !== 8) $display("FAIL sweep_pulses: got %0d want 8", pulses);
      else passed++;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (i >= pulses) $display("FAIL sweep_missing_code%0d: got none want code %0d", i, i);
         else if (got_code[i] !== i || got_cnt[i] < exp_cnt[i] - 1 || got_cnt[i] > exp_cnt[i] + 1)
            $display("FAIL sweep_code%0d: code %0d count %0d want code %0d count %0d+-1", i, got_code[i], got_cnt[i], i, exp_cnt[i]);
         else passed++;
      end
      checks++;
      if (n_done !== n_last + 1) $display("FAIL sweep_done_timing: done at %0d want %0d", n_done, n_last + 1);
      else passed++;
      checks++;
      if (en_drops !== 0) $display("FAIL sweep_ring_en: dropped %0d cycles want 0", en_drops);
      else passed++;
      checks++;
      if (b_min < 16'd30 || b_min > 16'd32 || b_max < 16'd119 || b_max > 16'd121)
         $display("FAIL sweep_minmax: min %0d max %0d want 31+-1 120+-1", b_min, b_max);
      else passed++;
      tick;
      checks++;
      if ({b_busy, b_ring_en} !== 2'b00) $display("FAIL sweep_end: busy/en %b want 00", {b_busy, b_ring_en});
      else passed++;
   endtask

   task automatic test_abort;
      int n, stray;
      bit seen;
      b_sweep = 1'b1; b_start = 1'b1;
      tick; b_start = 1'b0; b_sweep = 1'b0;
      n = 1; seen = 0;
      while (n < 8000 && !seen) begin
         tick; n++;
         if (b_valid && b_res_code == 3'd2) seen = 1;
      end
      checks++;
      if (!seen) $display("FAIL abort_setup_timeout: no code 2 result within %0d cycles", n);
      else passed++;
      repeat (664) tick;
      b_abort = 1'b1;
      tick;
      b_abort = 1'b0;
      checks++;
      if ({b_busy, b_ring_en, b_valid, b_done} !== 4'b0000) $display("FAIL abort_idle: busy/en/valid/done %b want 0000", {b_busy, b_ring_en, b_valid, b_done});
      else passed++;
      stray = 0;
      repeat (3000) begin
         tick;
         if (b_valid || b_done || b_busy) stray++;
      end
      checks++;
      if (stray !== 0) $display("FAIL abort_quiet: %0d active cycles want 0", stray);
      else passed++;
      checks++;
      if (b_res_code !== 3'd2) $display("FAIL abort_result_kept: code %0d want 2", b_res_code);
      else passed++;
      checks++;
      if (b_min < 16'd30 || b_min > 16'd32 || b_max < 16'd119 || b_max > 16'd121)
         $display("FAIL abort_minmax_kept: min %0d max %0d want 31+-1 120+-1", b_min, b_max);
      else passed++;
   endtask

   task automatic test_async_reset;
      int n;
      a_code = 5'd9; a_start = 1'b1;
      tick; a_start = 1'b0;
      repeat (5) tick;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({a_busy, a_ring_en, a_freq_sel} !== 7'd0) $display("FAIL async_reset_ctrl: busy/en/sel %b want 0", {a_busy, a_ring_en, a_freq_sel});
      else passed++;
      checks++;
      if ({a_res_code, a_res_count} !== 21'd0) $display("FAIL async_reset_result: got %h want 0", {a_res_code, a_res_count});
      else passed++;
      checks++;
      if ({b_min, b_max} !== 32'd0) $display("FAIL async_reset_minmax: got %h want 0", {b_min, b_max});
      else passed++;
      #3 rst_n = 1'b1;
      tick;
      a_code = 5'd5; a_start = 1'b1;
      tick; a_start = 1'b0;
      n = 1;
      while (n < 2000 && !a_valid) begin tick; n++; end
      checks++;
      if (!a_valid || n !== 1017) $display("FAIL restart_latency: valid %b at %0d want 1 at 1017", a_valid, n);
      else passed++;
      checks++;
      if (a_res_code !== 5'd5 || a_res_count < 16'd49 || a_res_count > 16'd51)
         $display("FAIL restart_result: code %0d count %0d want 5 50+-1", a_res_code, a_res_count);
      else passed++;
      tick;
      checks++;
      if (a_done !== 1'b1) $display("FAIL restart_done: got %b want 1", a_done);
      else passed++;
   endtask

   initial begin
      test_reset;
      test_single_and_busy_start;
      test_saturation;
      test_sweep;
      test_abort;
      test_async_reset;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
